// File: rtl/data_ram_master_if.sv
// -----------------------------------------------------------------------------
// data_ram_master_if
//   Bundles the burst command channel, the write and read word streams, the
//   completion pulse and the data_ram port into one interface.
//   master : view used by data_ram_master (initiator of RAM traffic)
//   slave  : view used by the surrounding logic that issues commands, feeds
//            the write stream, drains the read stream and models the RAM.
//   Signals:
//     cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len : burst command handshake
//     wr_valid/wr_ready/wr_data                      : write-stream words
//     rd_valid/rd_ready/rd_data/rd_last              : read-stream words
//     done                                           : burst-complete pulse
//     ram_addr/ram_data/ram_we/ram_dout              : data_ram port
// -----------------------------------------------------------------------------
interface data_ram_master_if #(
   parameter int DWIDTH     = 16,
   parameter int ADDR_WIDTH = 17,
   parameter int LEN_WIDTH  = 8
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [LEN_WIDTH-1:0]  cmd_len;
   logic                  wr_valid;
   logic                  wr_ready;
   logic [DWIDTH-1:0]     wr_data;
   logic                  rd_valid;
   logic                  rd_ready;
   logic [DWIDTH-1:0]     rd_data;
   logic                  rd_last;
   logic                  done;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DWIDTH-1:0]     ram_data;
   logic                  ram_we;
   logic [DWIDTH-1:0]     ram_dout;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len,
      input  wr_valid, wr_data, rd_ready, ram_dout,
      output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done,
      output ram_addr, ram_data, ram_we
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_len,
      output wr_valid, wr_data, rd_ready, ram_dout,
      input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done,
      input  ram_addr, ram_data, ram_we
   );
endinterface

// File: rtl/data_ram_master.sv
// -----------------------------------------------------------------------------
// data_ram_master
//   Initiator side of data_ram. Accepts one burst command at a time and either
//   streams words into the RAM (write burst) or streams them out (read burst).
//   The RAM returns read data one cycle after the address is presented; a
//   2-entry FIFO absorbs that latency so the read stream can run at one word
//   per cycle and stall without losing words.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : synchronous active-low reset (also gates ram_we combinationally)
//     bus   : data_ram_master_if.master (command, streams, done, RAM port)
// -----------------------------------------------------------------------------
module data_ram_master #(
   parameter int DWIDTH     = 16,
   parameter int ADDR_WIDTH = 17,
   parameter int LEN_WIDTH  = 8
) (
   input logic              clk,
   input logic              rst_n,
   data_ram_master_if.master bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      READ   = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DWIDTH-1:0]     DATA_ZERO = {DWIDTH{1'b0}};

   state_t                state_r;
   state_t                state_nxt_s;
   logic [ADDR_WIDTH-1:0] addr_r;        // next RAM address to write / issue
   logic [LEN_WIDTH-1:0]  issue_rem_r;   // read addresses still to issue
   logic [LEN_WIDTH-1:0]  deliv_rem_r;   // words still to write / pop
   logic                  inflight_r;    // a read was issued last cycle
   logic [DWIDTH-1:0]     buf_r [2];
   logic                  wr_ptr_r;
   logic                  rd_ptr_r;
   logic [1:0]            count_r;

   logic                  cmd_acc_s;
   logic                  acc_issue_s;
   logic                  wr_acc_s;
   logic                  rd_valid_s;
   logic                  pop_s;
   logic                  issue_s;
   logic [2:0]            occ_s;

   // Handshake decode and read-issue throttling.
   always_comb begin
      cmd_acc_s   = (state_r == IDLE) && bus.cmd_valid;
      // The first read address goes out in the accept cycle itself so the
      // first word can be presented two cycles after the command.
      acc_issue_s = cmd_acc_s && !bus.cmd_write && (bus.cmd_len != LEN_ZERO);
      wr_acc_s    = (state_r == WRITE) && bus.wr_valid;
      rd_valid_s  = (count_r != 2'd0);
      pop_s       = rd_valid_s && bus.rd_ready;
      // Occupancy the FIFO will have once this cycle's pop and last cycle's
      // read have landed; a new issue must still leave room for its word.
      occ_s       = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
      issue_s     = (state_r == READ) && (issue_rem_r != LEN_ZERO) && (occ_s < 3'd2);
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (cmd_acc_s) begin
               if (bus.cmd_len == LEN_ZERO) begin
                  state_nxt_s = FINISH;
               end else if (bus.cmd_write) begin
                  state_nxt_s = WRITE;
               end else begin
                  state_nxt_s = READ;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WRITE: begin
            if (wr_acc_s && (deliv_rem_r == LEN_ONE)) begin
               state_nxt_s = FINISH;
            end else begin
               state_nxt_s = WRITE;
            end
         end
         READ: begin
            if (pop_s && (deliv_rem_r == LEN_ONE)) begin
               state_nxt_s = FINISH;
            end else begin
               state_nxt_s = READ;
            end
         end
         FINISH:  state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Address and length counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_r      <= ADDR_ZERO;
         issue_rem_r <= LEN_ZERO;
         deliv_rem_r <= LEN_ZERO;
         inflight_r  <= 1'b0;
      end else begin
         inflight_r <= acc_issue_s || issue_s;
         case (state_r)
            IDLE: begin
               if (cmd_acc_s) begin
                  addr_r      <= acc_issue_s ? (bus.cmd_addr + ADDR_ONE) : bus.cmd_addr;
                  issue_rem_r <= acc_issue_s ? (bus.cmd_len - LEN_ONE) : bus.cmd_len;
                  deliv_rem_r <= bus.cmd_len;
               end
            end
            WRITE: begin
               if (wr_acc_s) begin
                  addr_r      <= addr_r + ADDR_ONE;
                  deliv_rem_r <= deliv_rem_r - LEN_ONE;
               end
            end
            READ: begin
               if (issue_s) begin
                  addr_r      <= addr_r + ADDR_ONE;
                  issue_rem_r <= issue_rem_r - LEN_ONE;
               end
               if (pop_s) begin
                  deliv_rem_r <= deliv_rem_r - LEN_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Two-entry read FIFO; ram_dout is captured the cycle after an issue.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         buf_r[0] <= DATA_ZERO;
         buf_r[1] <= DATA_ZERO;
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (inflight_r) begin
            buf_r[wr_ptr_r] <= bus.ram_dout;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         count_r <= count_r + {1'b0, inflight_r} - {1'b0, pop_s};
      end
   end

   assign bus.cmd_ready = (state_r == IDLE);
   assign bus.wr_ready  = (state_r == WRITE);
   assign bus.rd_valid  = rd_valid_s;
   assign bus.rd_data   = buf_r[rd_ptr_r];
   assign bus.rd_last   = rd_valid_s && (deliv_rem_r == LEN_ONE);
   assign bus.done      = (state_r == FINISH);
   assign bus.ram_we    = rst_n && wr_acc_s;
   assign bus.ram_data  = (state_r == WRITE) ? bus.wr_data : DATA_ZERO;
   assign bus.ram_addr  = acc_issue_s ? bus.cmd_addr : addr_r;

endmodule

// File: tb/tb_data_ram_master.sv
// -----------------------------------------------------------------------------
// tb_data_ram_master
//   Directed bench for data_ram_master with a behavioural data_ram
//   (registered read address, write on ram_we). Inputs change and outputs are
//   checked just after the falling edge.
// -----------------------------------------------------------------------------
module tb_data_ram_master;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   data_ram_master_if #(.DWIDTH(16), .ADDR_WIDTH(17), .LEN_WIDTH(8)) bus ();

   data_ram_master #(.DWIDTH(16), .ADDR_WIDTH(17), .LEN_WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural data_ram.
   logic [15:0] mem [0:131071];
   logic [16:0] addr_q;
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
      addr_q <= bus.ram_addr;
   end
   assign bus.ram_dout = mem[addr_q];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  pat;
      logic [15:0] held;
      logic        stalled;
      logic        seen_done;
      int          k;

      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 17'h0;
      bus.cmd_len   = 8'd0;
      bus.wr_valid  = 1'b1;
      bus.wr_data   = 16'hDEAD;
      bus.rd_ready  = 1'b0;

      // 1. reset with wr_valid high
      @(negedge clk); #1;
      chk("rst_we_c0", bus.ram_we, 1'b0);
      @(negedge clk); #1;
      chk("rst_we_c1", bus.ram_we, 1'b0);
      chk("rst_rd_valid", bus.rd_valid, 1'b0);
      chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
      chk("rst_wr_ready", bus.wr_ready, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_ram_addr", bus.ram_addr, 17'h0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.wr_valid = 1'b0;

      // 2. write 0x10 len 4
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 17'h10; bus.cmd_len = 8'd4;
      bus.wr_valid = 1'b1; bus.wr_data = 16'hBEEF;
      #1;
      chk("wr_accept_ready", bus.cmd_ready, 1'b1);
      chk("wr_accept_we", bus.ram_we, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         bus.wr_data = 16'hA001 + 16'(i);
         #1;
         chk("wr_we", bus.ram_we, 1'b1);
         chk("wr_addr", bus.ram_addr, 17'h10 + 17'(i));
         chk("wr_data", bus.ram_data, 16'hA001 + 16'(i));
         chk("wr_ready", bus.wr_ready, 1'b1);
         chk("wr_done_early", bus.done, 1'b0);
      end
      @(negedge clk);
      #1;
      chk("wr_done", bus.done, 1'b1);
      chk("wr_finish_we", bus.ram_we, 1'b0);
      chk("wr_finish_cmd_ready", bus.cmd_ready, 1'b0);
      bus.wr_valid = 1'b0;
      @(negedge clk); #1;
      chk("wr_done_pulse", bus.done, 1'b0);
      chk("wr_idle_ready", bus.cmd_ready, 1'b1);

      // 3. read back 0x10 len 4, rd_ready always high
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 17'h10; bus.cmd_len = 8'd4;
      bus.rd_ready = 1'b1;
      #1;
      chk("rd_issue_addr", bus.ram_addr, 17'h10);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #1;
      chk("rd_lat_c1", bus.rd_valid, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk("rd_valid", bus.rd_valid, 1'b1);
         chk("rd_data", bus.rd_data, 16'hA001 + 16'(i));
         chk("rd_last", bus.rd_last, (i == 3) ? 1'b1 : 1'b0);
         chk("rd_we", bus.ram_we, 1'b0);
      end
      @(negedge clk); #1;
      chk("rd_done", bus.done, 1'b1);
      chk("rd_done_valid", bus.rd_valid, 1'b0);
      @(negedge clk); #1;
      chk("rd_done_pulse", bus.done, 1'b0);

      // 4. read with rd_ready 1,0,0,1 pattern
      pat = 4'b1001;
      k = 0;
      stalled = 1'b0;
      seen_done = 1'b0;
      held = 16'h0;
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 17'h10; bus.cmd_len = 8'd4;
      for (int c = 0; c < 40 && !seen_done; c++) begin
         if (c > 0) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
         end
         bus.rd_ready = pat[c % 4];
         #1;
         if (bus.done) begin
            seen_done = 1'b1;
         end else begin
            if (stalled) begin
               chk("stall_valid", bus.rd_valid, 1'b1);
               chk("stall_data", bus.rd_data, held);
            end
            if (bus.rd_valid && bus.rd_ready) begin
               chk("stall_rd_data", bus.rd_data, 16'hA001 + 16'(k));
               chk("stall_rd_last", bus.rd_last, (k == 3) ? 1'b1 : 1'b0);
               k++;
               stalled = 1'b0;
            end else if (bus.rd_valid) begin
               stalled = 1'b1;
               held = bus.rd_data;
            end else begin
               stalled = 1'b0;
            end
         end
      end
      chk("stall_done_seen", seen_done, 1'b1);
      chk("stall_word_count", k, 4);
      bus.rd_ready = 1'b1;
      @(negedge clk); #1;
      chk("stall_done_pulse", bus.done, 1'b0);

      // 5. write across the address wrap, then a zero-length burst
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 17'h1FFFF; bus.cmd_len = 8'd2;
      bus.wr_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         bus.wr_data = 16'hB001 + 16'(i);
         #1;
         chk("wrap_we", bus.ram_we, 1'b1);
         chk("wrap_addr", bus.ram_addr, (i == 0) ? 17'h1FFFF : 17'h00000);
      end
      @(negedge clk); #1;
      chk("wrap_done", bus.done, 1'b1);
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 17'h20; bus.cmd_len = 8'd0;
      #1;
      chk("len0_accept_we", bus.ram_we, 1'b0);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #1;
      chk("len0_done", bus.done, 1'b1);
      chk("len0_we", bus.ram_we, 1'b0);
      chk("len0_wr_ready", bus.wr_ready, 1'b0);
      @(negedge clk);
      bus.wr_valid = 1'b0;
      #1;
      chk("len0_done_pulse", bus.done, 1'b0);
      chk("len0_idle", bus.cmd_ready, 1'b1);

      // 6. reset in the middle of a read burst
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 17'h10; bus.cmd_len = 8'd4;
      bus.rd_ready = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk); #1;
      chk("mid_rst_w0", bus.rd_data, 16'hA001);
      @(negedge clk); #1;
      chk("mid_rst_w1", bus.rd_data, 16'hA002);
      @(negedge clk);
      bus.rd_ready = 1'b0;
      rst_n = 1'b0;
      @(negedge clk); #1;
      chk("mid_rst_valid", bus.rd_valid, 1'b0);
      chk("mid_rst_done", bus.done, 1'b0);
      chk("mid_rst_idle", bus.cmd_ready, 1'b1);
      rst_n = 1'b1;
      bus.rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("post_rst_done", bus.done, 1'b0);
         chk("post_rst_valid", bus.rd_valid, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
